input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream front-end for the BasicFSM controller: takes two raw, asynchronous, possibly bouncing inputs (push-buttons/switches) and produces clean, synchronised levels `a` and `b` that drive the FSM inputs directly.
- Adds one-cycle rise/fall pulses per channel for event-driven consumers.
- Two identical channels. Each has a 2-flop synchroniser, a 4-state debounce FSM and a stability counter.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples of the new value required before the output level changes; legal range 2..65535.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES+1): counter width, derived; never overridden.

Ports:
- clock  input  1  single system clock, rising edge.
- reset_n  input  1  reset, synchronous and active-low; sampled only on the rising clock edge.
- raw_a  input  1  asynchronous raw input, channel A.
- raw_b  input  1  asynchronous raw input, channel B.
- a  output  1  debounced level A; feeds the controller's `a`.
- b  output  1  debounced level B; feeds the controller's `b`.
- a_rise  output  1  one-cycle pulse when `a` goes 0->1.
- a_fall  output  1  one-cycle pulse when `a` goes 1->0.
- b_rise  output  1  one-cycle pulse when `b` goes 0->1.
- b_fall  output  1  one-cycle pulse when `b` goes 1->0.
- busy  output  1  high while either channel is in a WAIT state.

Behaviour:
- Reset: reset_n=0 at a rising edge clears the following. Mid-operation reset aborts any pending transition; no pulse is emitted.
  - synchroniser flops = 0
  - counters = 0
  - FSM = STABLE_LOW
  - all outputs = 0
- Synchroniser: sync1 <= raw, then sync2 <= sync1. Only sync2 is used downstream.
- Per-channel FSM states:
  - STABLE_LOW:
    - sync2=1 -> WAIT_HIGH, cnt=1.
    - Else stay, cnt=0.
  - WAIT_HIGH:
    - sync2=0 -> STABLE_LOW, cnt=0. Glitch rejected, no pulse.
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, level<=1, rise<=1, cnt=0.
    - sync2=1 otherwise -> cnt<=cnt+1.
  - STABLE_HIGH: mirror of STABLE_LOW on sync2=0 -> WAIT_LOW.
  - WAIT_LOW: mirror of WAIT_HIGH; completes to STABLE_LOW with level<=0 and fall<=1.
- All outputs are registered. The level and its pulse assert on the same edge. The pulse deasserts on the next edge unconditionally.
- Latency: raw stable from edge 1 -> level changes visible after edge DEBOUNCE_CYCLES+2 (2 sync + N qualifying samples). With N=4 that is edge 6.
- A bounce that breaks the run of N samples restarts qualification from scratch. There is no partial credit.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap is possible.
- Channels are fully independent. Simultaneous transitions on A and B produce pulses in the same cycle.
- Output `busy` = OR of (state is WAIT_*) over both channels. It is combinational from registered state.
- Rise and fall never coexist on a channel. Level is constant while in WAIT_*.

Decomposition:
- Package input_conditioner_pkg holds:
  - the 2-bit state encodings: STABLE_LOW=2'b00, WAIT_HIGH=2'b01, STABLE_HIGH=2'b10, WAIT_LOW=2'b11
  - the synchroniser depth constant (2)
- Sub-module debounce_channel (synchroniser + FSM + counter, ports clock, reset_n, raw, level, rise, fall, waiting) is instantiated twice.
- The top level contains only the two instances and the `busy` OR.

Test Plan:
- Reset: hold reset_n=0 for 3 edges with raw_a=raw_b=1 -> all outputs 0. After release, a=b=1 visible after edge 6, with a_rise=b_rise=1 for exactly that one cycle.
- Clean press (N=4): raw_a 0->1 held -> busy=1 from edge 3; a=1 and a_rise=1 after edge 6; a_rise=0 after edge 7; busy=0 after edge 6.
- Bounce: raw_a pattern 1,1,0,1,1,1,1,1 (one value per cycle) -> the glitch resets qualification. Output a rises only after 4 consecutive synchronised 1s, i.e. 3 edges later than a clean press; exactly one a_rise pulse.
- Short glitch: raw_b=1 for 2 cycles, then 0 -> b stays 0, no b_rise or b_fall; busy pulses high, then returns to 0.
- Simultaneous release: from a=b=1, drop raw_a and raw_b on the same edge -> a_fall and b_fall assert on the same cycle, and a=b=0 together.
- Reset mid-WAIT: raw_a=1 for 3 qualifying cycles, then reset_n=0 for one edge -> a=0, no a_rise, FSM back in STABLE_LOW. The press then re-qualifies from scratch after release.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: debounce FSM encoding,
// synchroniser depth and a state classification helper.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    WAIT_LOW    = 2'b11
  } state_t;

  localparam int SYNC_DEPTH = 2;

  function automatic logic is_wait(input state_t s);
    return (s == WAIT_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw inputs and conditioned outputs of the input conditioner.
// The master side drives the raw inputs and the slave side is the conditioner.
interface input_conditioner_if;
  logic raw_a;
  logic raw_b;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;
  logic busy;

  modport master (
    output raw_a, raw_b,
    input  a, b, a_rise, a_fall, b_rise, b_fall, busy
  );

  modport slave (
    input  raw_a, raw_b,
    output a, b, a_rise, a_fall, b_rise, b_fall, busy
  );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One debounce channel: a 2-flop synchroniser followed by a 4-state FSM.
// The level changes only after DEBOUNCE_CYCLES consecutive samples of the new value.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic waiting
);
  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] r_sync;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic                  r_level;
  logic                  r_rise;
  logic                  r_fall;
  logic                  w_level_nxt;
  logic                  w_rise_nxt;
  logic                  w_fall_nxt;
  logic                  w_sample;

  assign w_sample = r_sync[SYNC_DEPTH-1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync  <= {SYNC_DEPTH{1'b0}};
      r_state <= STABLE_LOW;
      r_cnt   <= {CNT_WIDTH{1'b0}};
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_DEPTH-2:0], raw};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      STABLE_LOW: begin
        if (w_sample) w_state_nxt = WAIT_HIGH;
        else          w_state_nxt = STABLE_LOW;
      end
      WAIT_HIGH: begin
        if (!w_sample)              w_state_nxt = STABLE_LOW;
        else if (r_cnt == CNT_LAST) w_state_nxt = STABLE_HIGH;
        else                        w_state_nxt = WAIT_HIGH;
      end
      STABLE_HIGH: begin
        if (!w_sample) w_state_nxt = WAIT_LOW;
        else           w_state_nxt = STABLE_HIGH;
      end
      WAIT_LOW: begin
        if (w_sample)               w_state_nxt = STABLE_HIGH;
        else if (r_cnt == CNT_LAST) w_state_nxt = STABLE_LOW;
        else                        w_state_nxt = WAIT_LOW;
      end
      default: w_state_nxt = STABLE_LOW;
    endcase
  end

  // A broken run drops the count to zero: qualification never resumes mid-way.
  always_comb begin
    w_cnt_nxt   = {CNT_WIDTH{1'b0}};
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE_LOW: begin
        if (w_sample) w_cnt_nxt = CNT_WIDTH'(1'b1);
        else          w_cnt_nxt = {CNT_WIDTH{1'b0}};
      end
      WAIT_HIGH: begin
        if (!w_sample) begin
          w_cnt_nxt = {CNT_WIDTH{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1'b1);
        end
      end
      STABLE_HIGH: begin
        if (!w_sample) w_cnt_nxt = CNT_WIDTH'(1'b1);
        else           w_cnt_nxt = {CNT_WIDTH{1'b0}};
      end
      WAIT_LOW: begin
        if (w_sample) begin
          w_cnt_nxt = {CNT_WIDTH{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1'b1);
        end
      end
      default: w_level_nxt = 1'b0;
    endcase
  end

  assign level   = r_level;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign waiting = is_wait(r_state);

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounce channels feeding the controller inputs a and b,
// plus a busy flag raised while either channel is qualifying a change.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input_conditioner_if.slave bus
);
  logic w_wait_a;
  logic w_wait_b;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (bus.raw_a),
    .level   (bus.a),
    .rise    (bus.a_rise),
    .fall    (bus.a_fall),
    .waiting (w_wait_a)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (bus.raw_b),
    .level   (bus.b),
    .rise    (bus.b_rise),
    .fall    (bus.b_fall),
    .waiting (w_wait_b)
  );

  assign bus.busy = w_wait_a | w_wait_b;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed and randomized checks of input_conditioner against a run-length
// reference model of the debounce rules.
module tb_input_conditioner;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  input_conditioner_if ifc ();

  input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: raw delay line, level, length of current run of samples differing from level.
  bit pipe [2][2];
  int run [2];
  bit lvl [2];
  bit m_rise [2];
  bit m_fall [2];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit ra, input bit rb, input bit rn);
    bit raw [2];
    bit s;
    raw[0] = ra;
    raw[1] = rb;
    for (int c = 0; c < 2; c++) begin
      if (!rn) begin
        pipe[c][0] = 1'b0;
        pipe[c][1] = 1'b0;
        run[c] = 0;
        lvl[c] = 1'b0;
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
      end else begin
        s = pipe[c][0];
        pipe[c][0] = pipe[c][1];
        pipe[c][1] = raw[c];
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (s != lvl[c]) begin
          run[c]++;
          if (run[c] == N) begin
            lvl[c] = s;
            m_rise[c] = s;
            m_fall[c] = !s;
            run[c] = 0;
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  endtask

  task automatic step(input bit ra, input bit rb, input bit rn);
    ifc.raw_a = ra;
    ifc.raw_b = rb;
    reset_n = rn;
    @(posedge clock);
    model_edge(ra, rb, rn);
    #1;
    chk1("a", ifc.a, lvl[0]);
    chk1("b", ifc.b, lvl[1]);
    chk1("a_rise", ifc.a_rise, m_rise[0]);
    chk1("a_fall", ifc.a_fall, m_fall[0]);
    chk1("b_rise", ifc.b_rise, m_rise[1]);
    chk1("b_fall", ifc.b_fall, m_fall[1]);
    chk1("busy", ifc.busy, (run[0] > 0) || (run[1] > 0));
  endtask

  initial begin
    int ea, eb, n_ev, busy_edge;
    bit busy_at6, rise_at7, busy_seen, b_seen_high, a_at, b_at;
    bit pat [8];
    bit ra, rb;
    int ha, hb;

    // Reset with raw inputs high, then release.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("rst_outputs", {28'd0, ifc.a, ifc.b, ifc.a_rise, ifc.b_rise}, 0);
    chk1("rst_busy", ifc.busy, 1'b0);
    ea = 0; eb = 0; n_ev = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (ifc.a_rise === 1'b1) begin
        n_ev++;
        if (ea == 0) ea = k;
      end
      if (ifc.b_rise === 1'b1 && eb == 0) eb = k;
    end
    chk("rst_rise_a_edge", ea, 6);
    chk("rst_rise_b_edge", eb, 6);
    chk("rst_rise_a_count", n_ev, 1);

    // Clean press on A.
    repeat (10) step(1'b0, 1'b1, 1'b1);
    ea = 0; busy_edge = 0; busy_at6 = 1'b1; rise_at7 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b1);
      if (ifc.busy === 1'b1 && busy_edge == 0) busy_edge = k;
      if (ifc.a_rise === 1'b1 && ea == 0) ea = k;
      if (k == 6) busy_at6 = ifc.busy;
      if (k == 7) rise_at7 = ifc.a_rise;
    end
    chk("press_busy_edge", busy_edge, 3);
    chk("press_rise_edge", ea, 6);
    chk1("press_busy_after6", busy_at6, 1'b0);
    chk1("press_rise_after7", rise_at7, 1'b0);

    // Bouncing press on A.
    repeat (10) step(1'b0, 1'b1, 1'b1);
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ea = 0; n_ev = 0;
    for (int k = 1; k <= 14; k++) begin
      step((k <= 8) ? pat[k-1] : 1'b1, 1'b1, 1'b1);
      if (ifc.a_rise === 1'b1) begin
        n_ev++;
        if (ea == 0) ea = k;
      end
    end
    chk("bounce_rise_edge", ea, 9);
    chk("bounce_rise_count", n_ev, 1);

    // Short glitch on B.
    repeat (10) step(1'b1, 1'b0, 1'b1);
    n_ev = 0; busy_seen = 1'b0; b_seen_high = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, (k <= 2) ? 1'b1 : 1'b0, 1'b1);
      if (ifc.b_rise === 1'b1 || ifc.b_fall === 1'b1) n_ev++;
      if (ifc.busy === 1'b1) busy_seen = 1'b1;
      if (ifc.b !== 1'b0) b_seen_high = 1'b1;
    end
    chk("glitch_b_pulses", n_ev, 0);
    chk1("glitch_b_level", b_seen_high, 1'b0);
    chk1("glitch_busy_seen", busy_seen, 1'b1);
    chk1("glitch_busy_final", ifc.busy, 1'b0);

    // Simultaneous release of A and B.
    repeat (10) step(1'b1, 1'b1, 1'b1);
    ea = 0; eb = 0; a_at = 1'b1; b_at = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0, 1'b1);
      if (ifc.a_fall === 1'b1 && ea == 0) begin
        ea = k;
        a_at = ifc.a;
        b_at = ifc.b;
      end
      if (ifc.b_fall === 1'b1 && eb == 0) eb = k;
    end
    chk("release_a_fall_edge", ea, 6);
    chk("release_b_fall_edge", eb, 6);
    chk("release_levels", {30'd0, a_at, b_at}, 0);

    // Reset while A is qualifying, then re-qualify from scratch.
    repeat (10) step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b0, 1'b1);
    chk1("midrst_busy_before", ifc.busy, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk1("midrst_a", ifc.a, 1'b0);
    chk1("midrst_rise", ifc.a_rise, 1'b0);
    chk1("midrst_busy", ifc.busy, 1'b0);
    ea = 0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 1'b1);
      if (ifc.a_rise === 1'b1 && ea == 0) ea = k;
    end
    chk("midrst_requal_edge", ea, 6);

    // Randomized held levels with occasional bounces and resets.
    ra = 1'b0; rb = 1'b0; ha = 0; hb = 0;
    for (int i = 0; i < 400; i++) begin
      if (ha == 0) begin
        ra = 1'($urandom_range(0, 1));
        ha = int'($urandom_range(1, 8));
      end
      if (hb == 0) begin
        rb = 1'($urandom_range(0, 1));
        hb = int'($urandom_range(1, 8));
      end
      ha--;
      hb--;
      step(ra, rb, ($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
